// File: rtl/req_encoder_4_2_pkg.sv
// Shared types and default sizes for the sequential request encoder.
package req_encoder_4_2_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_IDX_W = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/req_encoder_4_2_prio_enc_comb.sv
// Combinational priority encoder: index of the highest set bit of vec.
module prio_enc_comb #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder_4_2.sv
// Sequential 4-to-2 priority encoder: latches request pulses into a pending
// set and hands them out one index per handshake, highest bit first.
//
//  state  | meaning
//  S_IDLE | no index on offer; grants highest pending bit when one exists
//  S_HOLD | index on offer (out_valid=1), waiting for out_ready
module req_encoder_4_2 import req_encoder_4_2_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] served_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   clr_mask;
  logic [WIDTH-1:0]   merged;
  logic [IDX_W-1:0]   grant_idx;
  logic               pending_any;
  logic               grant;
  logic               ack;
  logic [CNT_W:0]     drop_sum;

  prio_enc_comb #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_prio (
    .vec(pending),
    .idx(grant_idx),
    .any(pending_any)
  );

  // Next-state logic; grant clears the chosen pending bit in the same cycle.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    ack      = 1'b0;
    clr_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (pending_any) begin
          grant    = 1'b1;
          clr_mask = WIDTH'(1) << grant_idx;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          ack     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses landing on an already-pending bit are merged; count them, saturating.
  always_comb begin
    merged   = in & pending & ~clr_mask;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < WIDTH; i++) begin
      drop_sum = drop_sum + {{CNT_W{1'b0}}, merged[i]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Pending set: new pulses win over the clear of the bit being granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | in;
  end

  // Output register: load on grant, drop valid on accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (grant) begin
      out       <= grant_idx;
      out_valid <= 1'b1;
    end else if (ack) begin
      out_valid <= 1'b0;
    end
  end

  // Served counter wraps; drop counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (ack) served_cnt <= served_cnt + CNT_W'(1);
      if (drop_sum[CNT_W]) drop_cnt <= '1;
      else                 drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  assign busy = (|pending) | out_valid;

endmodule

// File: tb/tb_req_encoder_4_2.sv
// Directed bench for req_encoder_4_2 with hand-computed expectations.
module tb_req_encoder_4_2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [1:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [7:0] served_cnt;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  req_encoder_4_2 dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .served_cnt(served_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    in = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out", int'(out), 0);
    check("rst_served", int'(served_cnt), 0);
    check("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;

    // Single request on bit2
    in = 4'b0100;
    tick();
    in = 4'b0000;
    check("single_t1_valid", int'(out_valid), 0);
    check("single_t1_busy", int'(busy), 1);
    tick();
    check("single_t2_valid", int'(out_valid), 1);
    check("single_t2_out", int'(out), 2);
    tick();
    check("single_t3_valid", int'(out_valid), 0);
    check("single_served", int'(served_cnt), 1);
    check("single_busy", int'(busy), 0);

    // Several simultaneous requests, descending grant order
    in = 4'b1011;
    tick();
    in = 4'b0000;
    check("multi_t1_valid", int'(out_valid), 0);
    tick();
    check("multi_g1_valid", int'(out_valid), 1);
    check("multi_g1_out", int'(out), 3);
    tick();
    check("multi_bubble1", int'(out_valid), 0);
    tick();
    check("multi_g2_valid", int'(out_valid), 1);
    check("multi_g2_out", int'(out), 1);
    tick();
    check("multi_bubble2", int'(out_valid), 0);
    tick();
    check("multi_g3_valid", int'(out_valid), 1);
    check("multi_g3_out", int'(out), 0);
    tick();
    check("multi_end_valid", int'(out_valid), 0);
    check("multi_served", int'(served_cnt), 4);
    check("multi_busy", int'(busy), 0);
    check("multi_drop", int'(drop_cnt), 0);

    // Backpressure with a higher request arriving during hold
    out_ready = 1'b0;
    in = 4'b0001;
    tick();
    in = 4'b0000;
    tick();
    check("bp_grant_valid", int'(out_valid), 1);
    check("bp_grant_out", int'(out), 0);
    for (int i = 0; i < 5; i++) begin
      in = (i == 0) ? 4'b1000 : 4'b0000;
      tick();
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_out", int'(out), 0);
    end
    in = 4'b0000;
    out_ready = 1'b1;
    tick();
    check("bp_accept_valid", int'(out_valid), 0);
    check("bp_served", int'(served_cnt), 5);
    check("bp_pending_busy", int'(busy), 1);
    tick();
    check("bp_next_valid", int'(out_valid), 1);
    check("bp_next_out", int'(out), 3);
    tick();
    check("bp_done_served", int'(served_cnt), 6);
    check("bp_done_busy", int'(busy), 0);

    // Merge while pending, then set-wins on the grant cycle
    out_ready = 1'b0;
    in = 4'b1000;
    tick();
    in = 4'b0000;
    tick();
    check("merge_hold_out", int'(out), 3);
    in = 4'b0010;
    tick();
    in = 4'b0010;
    tick();
    in = 4'b0000;
    check("merge_drop", int'(drop_cnt), 1);
    out_ready = 1'b1;
    tick();
    check("merge_accept_valid", int'(out_valid), 0);
    check("merge_served", int'(served_cnt), 7);
    in = 4'b0010;
    tick();
    in = 4'b0000;
    check("setwin_g1_valid", int'(out_valid), 1);
    check("setwin_g1_out", int'(out), 1);
    check("setwin_no_drop", int'(drop_cnt), 1);
    tick();
    check("setwin_acc1_valid", int'(out_valid), 0);
    check("setwin_repend_busy", int'(busy), 1);
    tick();
    check("setwin_g2_valid", int'(out_valid), 1);
    check("setwin_g2_out", int'(out), 1);
    tick();
    check("setwin_served", int'(served_cnt), 9);
    check("setwin_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a hold with out=11
    out_ready = 1'b0;
    in = 4'b1000;
    tick();
    in = 4'b0100;
    tick();
    in = 4'b0000;
    check("rsthold_valid", int'(out_valid), 1);
    check("rsthold_out", int'(out), 3);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_served", int'(served_cnt), 0);
    check("async_rst_drop", int'(drop_cnt), 0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", int'(out_valid), 0);
      check("post_rst_busy", int'(busy), 0);
    end

    // Served counter wraps after 256 handshakes
    for (int k = 0; k < 256; k++) begin
      in = 4'b0001;
      tick();
      in = 4'b0000;
      tick();
      check("wrap_grant_valid", int'(out_valid), 1);
      tick();
      if (k == 254) check("wrap_served_255", int'(served_cnt), 255);
    end
    check("wrap_served_0", int'(served_cnt), 0);
    check("wrap_busy", int'(busy), 0);

    // Drop counter saturation while held
    out_ready = 1'b0;
    in = 4'b1000;
    tick();
    in = 4'b0000;
    tick();
    check("sat_hold_valid", int'(out_valid), 1);
    in = 4'b1111;
    for (int i = 0; i < 64; i++) tick();
    check("sat_drop_252", int'(drop_cnt), 252);
    tick();
    check("sat_drop_ff", int'(drop_cnt), 255);
    tick();
    check("sat_drop_stay", int'(drop_cnt), 255);
    in = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
